// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//
// Takes the decoded control and operands from ID and presents them, one cycle
// later, as registered ex_* outputs to EX. The combinational load_use_stall
// output freezes PC and IF/ID while a bubble is placed into EX. A branch flush
// from EX clears the entry.
//
// Operand-select encodings expected from the decoder:
//   operand1_type: 2'b00 = REG, 2'b01 = PC,  2'b10 = NULL
//   operand2_type: 2'b00 = REG, 2'b01 = IMM, 2'b10 = PC_PLUS4
//   op_type 3'b001 identifies a conditional branch, which also reads rs2.
//
// Optional feature: define IDEX_PERF_CNT_EN to add the 32-bit bubble_cnt
// output. It counts every cycle in which a load-use bubble is inserted.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // decoded instruction from ID
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [2:0]            id_op_type,
  input  logic                  id_is_jalr,
  input  logic                  id_is_br,
  input  logic                  id_mem_read_ena,
  input  logic                  id_mem_write_ena,
  input  logic                  id_reg_write_ena,
  input  logic                  id_mem2reg,
  input  logic [1:0]            id_operand1_type,
  input  logic [1:0]            id_operand2_type,
  // pipeline control from EX
  input  logic                  ex_hold,
  input  logic                  ex_flush,
  // registered instruction presented to EX
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [2:0]            ex_op_type,
  output logic                  ex_is_jalr,
  output logic                  ex_is_br,
  output logic                  ex_mem_read_ena,
  output logic                  ex_mem_write_ena,
  output logic                  ex_reg_write_ena,
  output logic                  ex_mem2reg,
  output logic [1:0]            ex_operand1_type,
  output logic [1:0]            ex_operand2_type,
`ifdef IDEX_PERF_CNT_EN
  output logic [31:0]           bubble_cnt,
`endif
  output logic                  load_use_stall
);

  localparam logic [1:0] OPND1_REG      = 2'b00;
  localparam logic [1:0] OPND2_REG      = 2'b00;
  localparam logic [2:0] OP_TYPE_BRANCH = 3'b001;

  // One ID/EX entry; an all-zero value is a bubble.
  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [2:0]            op_type;
    logic                  is_jalr;
    logic                  is_br;
    logic                  mem_read_ena;
    logic                  mem_write_ena;
    logic                  reg_write_ena;
    logic                  mem2reg;
    logic [1:0]            operand1_type;
    logic [1:0]            operand2_type;
  } stage_t;

  stage_t                stage_reg;
  stage_t                stage_next;
  stage_t                id_stage;

  logic                  uses_rs1;
  logic                  uses_rs2;
  logic                  ex_load_pending;
  logic [1:0]            src_used;
  logic [1:0]            src_hit;
  logic [REG_ADDR_W-1:0] src_idx [2];

  // Gather the ID fields. An invalid slot keeps its data but has no side effects.
  always_comb begin
    id_stage.valid         = id_valid;
    id_stage.pc            = id_pc;
    id_stage.rs1_data      = id_rs1_data;
    id_stage.rs2_data      = id_rs2_data;
    id_stage.imm           = id_imm;
    id_stage.rs1           = id_rs1;
    id_stage.rs2           = id_rs2;
    id_stage.rd            = id_rd;
    id_stage.funct3        = id_funct3;
    id_stage.op_type       = id_op_type;
    id_stage.is_jalr       = id_is_jalr       & id_valid;
    id_stage.is_br         = id_is_br         & id_valid;
    id_stage.mem_read_ena  = id_mem_read_ena  & id_valid;
    id_stage.mem_write_ena = id_mem_write_ena & id_valid;
    id_stage.reg_write_ena = id_reg_write_ena & id_valid;
    id_stage.mem2reg       = id_mem2reg       & id_valid;
    id_stage.operand1_type = id_operand1_type;
    id_stage.operand2_type = id_operand2_type;
  end

  // Work out which register sources the ID instruction really reads.
  // Stores read rs2 for the write data, and branches compare rs1 with rs2.
  assign uses_rs1    = (id_operand1_type == OPND1_REG);
  assign uses_rs2    = (id_operand2_type == OPND2_REG) | id_mem_write_ena |
                       (id_op_type == OP_TYPE_BRANCH);
  assign src_used[0] = uses_rs1;
  assign src_used[1] = uses_rs2;
  assign src_idx[0]  = id_rs1;
  assign src_idx[1]  = id_rs2;

  // A load in EX whose result is not ready until MEM. x0 is never a hazard.
  assign ex_load_pending = stage_reg.valid & stage_reg.mem_read_ena &
                           (stage_reg.rd != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_hit
      assign src_hit[gi] = src_used[gi] & (stage_reg.rd == src_idx[gi]);
    end
  endgenerate

  // A flush refetches IF/ID anyway, and a hold already freezes everything.
  // In both cases the stall is suppressed.
  assign load_use_stall = id_valid & ex_load_pending & (|src_hit) &
                          ~ex_flush & ~ex_hold;

  // Choose the next entry: flush > hold > load-use bubble > normal load.
  always_comb begin
    stage_next = stage_reg;
    if (ex_flush) begin
      stage_next = '0;
    end else if (ex_hold) begin
      stage_next = stage_reg;
    end else if (load_use_stall) begin
      stage_next = '0;
    end else begin
      stage_next = id_stage;
    end
  end

  // ID/EX register; reset empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign ex_valid         = stage_reg.valid;
  assign ex_pc            = stage_reg.pc;
  assign ex_rs1_data      = stage_reg.rs1_data;
  assign ex_rs2_data      = stage_reg.rs2_data;
  assign ex_imm           = stage_reg.imm;
  assign ex_rs1           = stage_reg.rs1;
  assign ex_rs2           = stage_reg.rs2;
  assign ex_rd            = stage_reg.rd;
  assign ex_funct3        = stage_reg.funct3;
  assign ex_op_type       = stage_reg.op_type;
  assign ex_is_jalr       = stage_reg.is_jalr;
  assign ex_is_br         = stage_reg.is_br;
  assign ex_mem_read_ena  = stage_reg.mem_read_ena;
  assign ex_mem_write_ena = stage_reg.mem_write_ena;
  assign ex_reg_write_ena = stage_reg.reg_write_ena;
  assign ex_mem2reg       = stage_reg.mem2reg;
  assign ex_operand1_type = stage_reg.operand1_type;
  assign ex_operand2_type = stage_reg.operand2_type;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt_reg;

  // Count inserted load-use bubbles. The stall already excludes flush and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
    end else if (load_use_stall) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scenario tasks drive ID/EX stimulus. Each clock edge pushes
// the expected EX entry to a scoreboard, which is popped and compared at the
// following negative edge. Build with IDEX_PERF_CNT_EN to exercise bubble_cnt.
module tb_id_ex_stage;

  localparam logic [1:0] OP1_REG  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_NULL = 2'b10;
  localparam logic [1:0] OP2_REG  = 2'b00;
  localparam logic [1:0] OP2_IMM  = 2'b01;
  localparam logic [1:0] OP2_PC4  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [2:0]  op_type;
    logic        is_jalr;
    logic        is_br;
    logic        mem_read_ena;
    logic        mem_write_ena;
    logic        reg_write_ena;
    logic        mem2reg;
    logic [1:0]  operand1_type;
    logic [1:0]  operand2_type;
  } fields_t;

  logic    clk;
  logic    rst;
  logic    ex_hold;
  logic    ex_flush;
  fields_t id_cur;
  fields_t ex_got;
  logic    load_use_stall;

  logic        ex_valid, ex_is_jalr, ex_is_br, ex_mem_read_ena, ex_mem_write_ena;
  logic        ex_reg_write_ena, ex_mem2reg;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3, ex_op_type;
  logic [1:0]  ex_operand1_type, ex_operand2_type;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  // model state and scoreboard
  fields_t     m;
  fields_t     sb [$];
  int unsigned exp_cnt;
  int          total;
  int          bad;

  id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_cur.valid),
    .id_pc            (id_cur.pc),
    .id_rs1_data      (id_cur.rs1_data),
    .id_rs2_data      (id_cur.rs2_data),
    .id_imm           (id_cur.imm),
    .id_rs1           (id_cur.rs1),
    .id_rs2           (id_cur.rs2),
    .id_rd            (id_cur.rd),
    .id_funct3        (id_cur.funct3),
    .id_op_type       (id_cur.op_type),
    .id_is_jalr       (id_cur.is_jalr),
    .id_is_br         (id_cur.is_br),
    .id_mem_read_ena  (id_cur.mem_read_ena),
    .id_mem_write_ena (id_cur.mem_write_ena),
    .id_reg_write_ena (id_cur.reg_write_ena),
    .id_mem2reg       (id_cur.mem2reg),
    .id_operand1_type (id_cur.operand1_type),
    .id_operand2_type (id_cur.operand2_type),
    .ex_hold          (ex_hold),
    .ex_flush         (ex_flush),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_rs1_data      (ex_rs1_data),
    .ex_rs2_data      (ex_rs2_data),
    .ex_imm           (ex_imm),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .ex_rd            (ex_rd),
    .ex_funct3        (ex_funct3),
    .ex_op_type       (ex_op_type),
    .ex_is_jalr       (ex_is_jalr),
    .ex_is_br         (ex_is_br),
    .ex_mem_read_ena  (ex_mem_read_ena),
    .ex_mem_write_ena (ex_mem_write_ena),
    .ex_reg_write_ena (ex_reg_write_ena),
    .ex_mem2reg       (ex_mem2reg),
    .ex_operand1_type (ex_operand1_type),
    .ex_operand2_type (ex_operand2_type),
`ifdef IDEX_PERF_CNT_EN
    .bubble_cnt       (bubble_cnt),
`endif
    .load_use_stall   (load_use_stall)
  );

  assign ex_got = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                   ex_rd, ex_funct3, ex_op_type, ex_is_jalr, ex_is_br, ex_mem_read_ena,
                   ex_mem_write_ena, ex_reg_write_ena, ex_mem2reg, ex_operand1_type,
                   ex_operand2_type};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic fields_t mk(input logic [2:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [1:0] o1, input logic [1:0] o2,
                                 input logic mr, input logic mw, input logic rw,
                                 input logic m2r, input logic br);
    fields_t f;
    f               = '0;
    f.valid         = 1'b1;
    f.pc            = $urandom;
    f.rs1_data      = $urandom;
    f.rs2_data      = $urandom;
    f.imm           = $urandom;
    f.funct3        = 3'($urandom_range(0, 7));
    f.op_type       = op;
    f.rd            = rd;
    f.rs1           = rs1;
    f.rs2           = rs2;
    f.operand1_type = o1;
    f.operand2_type = o2;
    f.mem_read_ena  = mr;
    f.mem_write_ena = mw;
    f.reg_write_ena = rw;
    f.mem2reg       = m2r;
    f.is_br         = br;
    return f;
  endfunction

  function automatic fields_t i_add(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return mk(3'b000, rd, rs1, rs2, OP1_REG, OP2_REG, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic fields_t i_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2_field);
    return mk(3'b000, rd, rs1, rs2_field, OP1_REG, OP2_IMM, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic fields_t i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return mk(3'b010, rd, rs1, 5'd0, OP1_REG, OP2_IMM, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic fields_t i_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(3'b011, 5'd0, rs1, rs2, OP1_REG, OP2_IMM, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic fields_t i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return mk(3'b001, 5'd0, rs1, rs2, OP1_REG, OP2_IMM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic fields_t i_jal(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return mk(3'b100, rd, rs1, rs2, OP1_PC, OP2_PC4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic fields_t i_lui(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return mk(3'b101, rd, rs1, rs2, OP1_NULL, OP2_IMM, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic model_stall();
    logic u1, u2;
    u1 = (id_cur.operand1_type == OP1_REG);
    u2 = (id_cur.operand2_type == OP2_REG) || id_cur.mem_write_ena ||
         (id_cur.op_type == 3'b001);
    return !ex_hold && !ex_flush && id_cur.valid && m.valid && m.mem_read_ena &&
           (m.rd != 5'd0) && ((u1 && m.rd == id_cur.rs1) || (u2 && m.rd == id_cur.rs2));
  endfunction

  // Predict the EX entry after the next edge, queue it, then advance one cycle.
  task automatic tick();
    fields_t nx;
    logic    st;
    st = model_stall();
    if (rst || ex_flush || st) begin
      nx = '0;
    end else if (ex_hold) begin
      nx = m;
    end else begin
      nx = id_cur;
      if (!id_cur.valid) begin
        nx.is_jalr       = 1'b0;
        nx.is_br         = 1'b0;
        nx.mem_read_ena  = 1'b0;
        nx.mem_write_ena = 1'b0;
        nx.reg_write_ena = 1'b0;
        nx.mem2reg       = 1'b0;
      end
    end
    if (rst) exp_cnt = 0;
    else if (st) exp_cnt = exp_cnt + 1;
    sb.push_back(nx);
    @(posedge clk);
    m = nx;
    #1;
  endtask

  // Scoreboard check: one line per transaction.
  always @(negedge clk) begin
    fields_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (ex_got !== e) begin
        bad++;
        $display("FAIL scoreboard_ex t=%0t got=%h exp=%h", $time, ex_got, e);
      end else begin
        $display("txn t=%0t ex_valid=%0b ex_rd=%0d stall=%0b", $time, ex_valid, ex_rd,
                 load_use_stall);
      end
      total++;
      if (load_use_stall !== model_stall()) begin
        bad++;
        $display("FAIL scoreboard_stall t=%0t got=%0b exp=%0b", $time, load_use_stall,
                 model_stall());
      end
`ifdef IDEX_PERF_CNT_EN
      total++;
      if (bubble_cnt !== exp_cnt) begin
        bad++;
        $display("FAIL scoreboard_bubble_cnt t=%0t got=%0d exp=%0d", $time, bubble_cnt,
                 exp_cnt);
      end
`endif
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst      = 1'b1;
    ex_hold  = 1'b0;
    ex_flush = 1'b0;
    id_cur   = i_add(5'd3, 5'd1, 5'd2);
    tick();
    id_cur   = i_lw(5'd4, 5'd1);
    tick();
    total++;
    if (ex_got !== '0) begin
      bad++;
      $display("FAIL reset_ex got=%h exp=0", ex_got);
    end
    total++;
    if (load_use_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%0b exp=0", load_use_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    id_cur = i_lw(5'd5, 5'd2);
    tick();
    id_cur = i_add(5'd6, 5'd5, 5'd1);
    #1;
    total++;
    if (load_use_stall !== 1'b1) begin
      bad++;
      $display("FAIL load_use_stall_on got=%0b exp=1", load_use_stall);
    end
    tick();
    total++;
    if (ex_valid !== 1'b0 || ex_mem_read_ena !== 1'b0) begin
      bad++;
      $display("FAIL load_use_bubble got_valid=%0b exp=0", ex_valid);
    end
    total++;
    if (load_use_stall !== 1'b0) begin
      bad++;
      $display("FAIL load_use_stall_drop got=%0b exp=0", load_use_stall);
    end
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6) begin
      bad++;
      $display("FAIL load_use_add_loaded got_valid=%0b rs1=%0d rd=%0d exp 1/5/6",
               ex_valid, ex_rs1, ex_rd);
    end
  endtask

  task automatic test_no_hazard();
    id_cur = i_lw(5'd0, 5'd3);
    tick();
    id_cur = i_add(5'd6, 5'd0, 5'd0);
    #1;
    total++;
    if (load_use_stall !== 1'b0) begin
      bad++;
      $display("FAIL x0_no_stall got=%0b exp=0", load_use_stall);
    end
    tick();
    id_cur = i_lw(5'd5, 5'd3);
    tick();
    id_cur = i_addi(5'd6, 5'd7, 5'd5);
    #1;
    total++;
    if (load_use_stall !== 1'b0) begin
      bad++;
      $display("FAIL unused_rs2_no_stall got=%0b exp=0", load_use_stall);
    end
    tick();
    total++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin
      bad++;
      $display("FAIL addi_loaded got_valid=%0b rd=%0d exp 1/6", ex_valid, ex_rd);
    end
  endtask

  task automatic test_flush();
    id_cur = i_lw(5'd5, 5'd1);
    tick();
    id_cur   = i_add(5'd6, 5'd5, 5'd1);
    ex_flush = 1'b1;
    ex_hold  = 1'b1;
    #1;
    total++;
    if (load_use_stall !== 1'b0) begin
      bad++;
      $display("FAIL flush_kills_stall got=%0b exp=0", load_use_stall);
    end
    tick();
    ex_flush = 1'b0;
    ex_hold  = 1'b0;
    total++;
    if (ex_valid !== 1'b0 || ex_reg_write_ena !== 1'b0) begin
      bad++;
      $display("FAIL flush_over_hold got_valid=%0b got_we=%0b exp 0/0", ex_valid,
               ex_reg_write_ena);
    end
  endtask

  task automatic test_hold();
    fields_t snap;
    snap   = i_lw(5'd5, 5'd2);
    id_cur = snap;
    tick();
    ex_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id_cur = i_add(5'(10 + k), 5'd5, 5'd5);
      #1;
      total++;
      if (load_use_stall !== 1'b0) begin
        bad++;
        $display("FAIL hold_stall_%0d got=%0b exp=0", k, load_use_stall);
      end
      tick();
      total++;
      if (ex_got !== snap) begin
        bad++;
        $display("FAIL hold_frozen_%0d got=%h exp=%h", k, ex_got, snap);
      end
    end
    ex_hold = 1'b0;
    id_cur  = i_add(5'd9, 5'd1, 5'd2);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    id_cur = i_lw(5'd7, 5'd1);
    tick();
    id_cur = i_sw(5'd2, 5'd7);
    #1;
    total++;
    if (load_use_stall !== 1'b1) begin
      bad++;
      $display("FAIL store_rs2_stall got=%0b exp=1", load_use_stall);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (load_use_stall !== 1'b0 || ex_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_stall got_stall=%0b got_valid=%0b exp 0/0",
               load_use_stall, ex_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 300; k++) begin
      logic [4:0] rd, rs1, rs2;
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0, 1:    id_cur = i_lw(rd, rs1);
        2:       id_cur = i_add(rd, rs1, rs2);
        3:       id_cur = i_addi(rd, rs1, rs2);
        4:       id_cur = i_sw(rs1, rs2);
        5:       id_cur = i_beq(rs1, rs2);
        default: id_cur = ($urandom_range(0, 1) == 0) ? i_jal(rd, rs1, rs2)
                                                      : i_lui(rd, rs1, rs2);
      endcase
      id_cur.valid   = ($urandom_range(0, 7) != 0);
      id_cur.is_jalr = ($urandom_range(0, 5) == 0);
      ex_hold        = ($urandom_range(0, 7) == 0);
      ex_flush       = ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst      = 1'b0;
    ex_hold  = 1'b0;
    ex_flush = 1'b0;
  endtask

`ifdef IDEX_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int h = 0; h < 3; h++) begin
      id_cur = i_lw(5'(5 + h), 5'd1);
      tick();
      id_cur = (h == 1) ? i_add(5'd12, 5'd3, 5'(5 + h)) : i_add(5'd12, 5'(5 + h), 5'd3);
      ex_flush = (h == 2);
      tick();
      ex_flush = 1'b0;
      tick();
    end
    total++;
    if (bubble_cnt !== 32'd2) begin
      bad++;
      $display("FAIL perf_bubble_cnt got=%0d exp=2", bubble_cnt);
    end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    exp_cnt  = 0;
    m        = '0;
    rst      = 1'b1;
    ex_hold  = 1'b0;
    ex_flush = 1'b0;
    id_cur   = '0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef IDEX_PERF_CNT_EN
    test_perf_cnt();
`endif
    id_cur = '0;
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
